// File: rtl/burst_read_pipeline_gen2.sv
// rtl/burst_read_pipeline_gen2.sv - burst read engine: address generator feeding a fixed-latency synthetic memory pipe
module burst_read_pipeline_gen2 #(
  parameter int DATA_WIDTH       = 32,
  parameter int ADDR_WIDTH       = 32,
  parameter int ID_WIDTH         = 4,
  parameter int MEM_LATENCY      = 2,
  parameter int MAX_BURST_LENGTH = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] u_addr,
  input  logic [7:0]            u_length,
  input  logic [1:0]            u_burst,
  input  logic [2:0]            u_size,
  input  logic [ID_WIDTH-1:0]   u_id,
  input  logic                  u_valid,
  output logic                  u_ready,
  output logic [DATA_WIDTH-1:0] d_data,
  output logic [ID_WIDTH-1:0]   d_id,
  output logic [1:0]            d_resp,
  output logic                  d_last,
  output logic                  d_valid,
  input  logic                  d_ready
);

  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;
  localparam logic [1:0] BURST_RSVD  = 2'd3;
  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [7:0] COUNT_IDLE  = 8'hFF;
  localparam int         COPY_W      = (DATA_WIDTH < ADDR_WIDTH) ? DATA_WIDTH : ADDR_WIDTH;
  // One stage per cycle of memory latency plus the output register.
  localparam int         STAGES      = MEM_LATENCY + 1;

  logic [7:0]            t0_count;
  logic [ADDR_WIDTH-1:0] t0_addr;
  logic [7:0]            t0_len;
  logic [1:0]            t0_burst;
  logic [2:0]            t0_size;
  logic [ID_WIDTH-1:0]   t0_id;
  logic                  t0_err;

  logic                  accept;
  logic                  t0_valid;
  logic                  cmd_err;
  logic [ADDR_WIDTH-1:0] step;
  logic [ADDR_WIDTH-1:0] wrap_mask;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [DATA_WIDTH-1:0] beat_data;

  logic [STAGES-1:0]     p_valid;
  logic [STAGES-1:0]     p_last;
  logic [DATA_WIDTH-1:0] p_data [STAGES];
  logic [ID_WIDTH-1:0]   p_id   [STAGES];
  logic [1:0]            p_resp [STAGES];

  assign u_ready  = d_ready && (t0_count == COUNT_IDLE || t0_count == 8'h00);
  assign accept   = u_valid && u_ready;
  assign t0_valid = (t0_count != COUNT_IDLE);

  always_comb begin
    cmd_err = 1'b0;
    if (u_burst == BURST_RSVD)
      cmd_err = 1'b1;
    if ({1'b0, u_length} + 9'd1 > 9'(MAX_BURST_LENGTH))
      cmd_err = 1'b1;
    if (u_burst == BURST_WRAP && !(u_length inside {8'd1, 8'd3, 8'd7, 8'd15}))
      cmd_err = 1'b1;
    if ((32'd1 << u_size) > 32'(DATA_WIDTH / 8))
      cmd_err = 1'b1;
  end

  always_comb begin
    step      = ADDR_WIDTH'(1) << t0_size;
    wrap_mask = ((ADDR_WIDTH'(t0_len) + ADDR_WIDTH'(1)) << t0_size) - ADDR_WIDTH'(1);
    next_addr = t0_addr;
    // FIXED bursts and error bursts keep the start address for every beat.
    if (!t0_err) begin
      case (t0_burst)
        BURST_INCR: next_addr = t0_addr + step;
        BURST_WRAP: next_addr = (t0_addr & ~wrap_mask) | ((t0_addr + step) & wrap_mask);
        default:    next_addr = t0_addr;
      endcase
    end
  end

  always_comb begin
    beat_data = '0;
    if (t0_valid && !t0_err)
      beat_data[COPY_W-1:0] = t0_addr[COPY_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      t0_count <= COUNT_IDLE;
      t0_addr  <= '0;
      t0_len   <= '0;
      t0_burst <= '0;
      t0_size  <= '0;
      t0_id    <= '0;
      t0_err   <= 1'b0;
    end else if (d_ready) begin
      if (accept) begin
        t0_count <= u_length;
        t0_addr  <= u_addr;
        t0_len   <= u_length;
        t0_burst <= u_burst;
        t0_size  <= u_size;
        t0_id    <= u_id;
        t0_err   <= cmd_err;
      end else if (t0_count == 8'h00) begin
        t0_count <= COUNT_IDLE;
      end else if (t0_valid) begin
        t0_count <= t0_count - 8'd1;
        t0_addr  <= next_addr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_valid <= '0;
      p_last  <= '0;
      for (int i = 0; i < STAGES; i++) begin
        p_data[i] <= '0;
        p_id[i]   <= '0;
        p_resp[i] <= RESP_OKAY;
      end
    end else if (d_ready) begin
      p_valid[0] <= t0_valid;
      p_last[0]  <= t0_valid && (t0_count == 8'h00);
      p_data[0]  <= beat_data;
      p_id[0]    <= t0_valid ? t0_id : '0;
      p_resp[0]  <= (t0_valid && t0_err) ? RESP_SLVERR : RESP_OKAY;
      for (int i = 1; i < STAGES; i++) begin
        p_valid[i] <= p_valid[i-1];
        p_last[i]  <= p_last[i-1];
        p_data[i]  <= p_data[i-1];
        p_id[i]    <= p_id[i-1];
        p_resp[i]  <= p_resp[i-1];
      end
    end
  end

  assign d_valid = p_valid[STAGES-1];
  assign d_last  = p_last[STAGES-1];
  assign d_data  = p_data[STAGES-1];
  assign d_id    = p_id[STAGES-1];
  assign d_resp  = p_resp[STAGES-1];

endmodule

// File: tb/tb_burst_read_pipeline_gen2.sv
// tb/tb_burst_read_pipeline_gen2.sv - directed self-checking bench for burst_read_pipeline_gen2
module tb_burst_read_pipeline_gen2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] u_addr;
  logic [7:0]  u_length;
  logic [1:0]  u_burst;
  logic [2:0]  u_size;
  logic [3:0]  u_id;
  logic        u_valid;
  logic        u_ready;
  logic [31:0] d_data;
  logic [3:0]  d_id;
  logic [1:0]  d_resp;
  logic        d_last;
  logic        d_valid;
  logic        d_ready;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [31:0] q_data [$];
  logic [3:0]  q_id   [$];
  logic [1:0]  q_resp [$];
  logic        q_last [$];
  int          q_cyc  [$];

  burst_read_pipeline_gen2 #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .ID_WIDTH(4), .MEM_LATENCY(2), .MAX_BURST_LENGTH(256)
  ) dut (
    .clk(clk), .rst(rst),
    .u_addr(u_addr), .u_length(u_length), .u_burst(u_burst), .u_size(u_size), .u_id(u_id),
    .u_valid(u_valid), .u_ready(u_ready),
    .d_data(d_data), .d_id(d_id), .d_resp(d_resp), .d_last(d_last), .d_valid(d_valid),
    .d_ready(d_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Records every beat that will be consumed at the coming rising edge.
  always @(negedge clk) begin
    #1;
    if (d_valid === 1'b1 && d_ready === 1'b1) begin
      q_data.push_back(d_data);
      q_id.push_back(d_id);
      q_resp.push_back(d_resp);
      q_last.push_back(d_last);
      q_cyc.push_back(cyc);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  task automatic clear_q();
    q_data.delete();
    q_id.delete();
    q_resp.delete();
    q_last.delete();
    q_cyc.delete();
  endtask

  // Returns the edge number at which the command is taken, or -1 if it never is.
  task automatic send_cmd(input logic [31:0] a, input logic [7:0] l, input logic [1:0] b,
                          input logic [2:0] s, input logic [3:0] i, output int acc_edge);
    int guard = 0;
    u_addr = a; u_length = l; u_burst = b; u_size = s; u_id = i; u_valid = 1'b1;
    #1;
    while (u_ready !== 1'b1 && guard < 200) begin
      @(negedge clk);
      #1;
      guard++;
    end
    acc_edge = (guard < 200) ? cyc + 1 : -1;
    @(negedge clk);
    u_valid = 1'b0;
  endtask

  task automatic wait_beats(input int n);
    int guard = 0;
    while (q_data.size() < n && guard < 100) begin
      @(negedge clk);
      #2;
      guard++;
    end
    repeat (6) @(negedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst = 1'b1; d_ready = 1'b1; u_valid = 1'b0;
    u_addr = '0; u_length = '0; u_burst = '0; u_size = '0; u_id = '0;
    repeat (3) @(negedge clk);
    #1;
    vectors++;
    if (d_valid !== 1'b0 || d_last !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_flags: d_valid=%b d_last=%b, expected 0 0", d_valid, d_last);
    end
    vectors++;
    if (d_data !== 32'h0 || d_id !== 4'h0 || d_resp !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_payload: data=%h id=%h resp=%0d, expected 0 0 0", d_data, d_id, d_resp);
    end
    vectors++;
    if (u_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_uready_hi: u_ready=%b, expected 1", u_ready);
    end
    d_ready = 1'b0;
    #1;
    vectors++;
    if (u_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_uready_lo: u_ready=%b, expected 0", u_ready);
    end
    d_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_incr();
    int acc;
    logic [31:0] exp_d [4];
    exp_d = '{32'h100, 32'h104, 32'h108, 32'h10C};
    clear_q();
    send_cmd(32'h100, 8'd3, 2'd1, 3'd2, 4'd5, acc);
    wait_beats(4);
    vectors++;
    if (q_data.size() != 4) begin
      miscompares++;
      $display("FAIL incr_count: got %0d beats, expected 4", q_data.size());
    end else begin
      vectors++;
      if (q_cyc[0] != acc + 3) begin
        miscompares++;
        $display("FAIL incr_latency: first beat at edge %0d, expected %0d", q_cyc[0], acc + 3);
      end
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (q_data[i] !== exp_d[i] || q_id[i] !== 4'd5 || q_resp[i] !== 2'd0 ||
            q_last[i] !== (i == 3) || q_cyc[i] != q_cyc[0] + i) begin
          miscompares++;
          $display("FAIL incr_beat%0d: data=%h id=%0d resp=%0d last=%b, expected data=%h id=5 resp=0 last=%b contiguous",
                   i, q_data[i], q_id[i], q_resp[i], q_last[i], exp_d[i], (i == 3));
        end
      end
    end
  endtask

  task automatic test_wrap_fixed();
    int acc;
    logic [31:0] exp_d [4];
    exp_d = '{32'h38, 32'h3C, 32'h30, 32'h34};
    clear_q();
    send_cmd(32'h38, 8'd3, 2'd2, 3'd2, 4'd2, acc);
    wait_beats(4);
    vectors++;
    if (q_data.size() != 4) begin
      miscompares++;
      $display("FAIL wrap_count: got %0d beats, expected 4", q_data.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (q_data[i] !== exp_d[i] || q_resp[i] !== 2'd0 || q_last[i] !== (i == 3)) begin
          miscompares++;
          $display("FAIL wrap_beat%0d: data=%h resp=%0d last=%b, expected data=%h resp=0 last=%b",
                   i, q_data[i], q_resp[i], q_last[i], exp_d[i], (i == 3));
        end
      end
    end
    clear_q();
    send_cmd(32'h20, 8'd2, 2'd0, 3'd2, 4'd3, acc);
    wait_beats(3);
    vectors++;
    if (q_data.size() != 3) begin
      miscompares++;
      $display("FAIL fixed_count: got %0d beats, expected 3", q_data.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (q_data[i] !== 32'h20 || q_id[i] !== 4'd3 || q_last[i] !== (i == 2)) begin
          miscompares++;
          $display("FAIL fixed_beat%0d: data=%h id=%0d last=%b, expected data=00000020 id=3 last=%b",
                   i, q_data[i], q_id[i], q_last[i], (i == 2));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int acc1, acc2;
    logic [31:0] exp_d  [4];
    logic [3:0]  exp_id [4];
    logic        exp_l  [4];
    exp_d  = '{32'hFFFF_FFFC, 32'h0000_0000, 32'h200, 32'h204};
    exp_id = '{4'd3, 4'd3, 4'd9, 4'd9};
    exp_l  = '{1'b0, 1'b1, 1'b0, 1'b1};
    clear_q();
    send_cmd(32'hFFFF_FFFC, 8'd1, 2'd1, 3'd2, 4'd3, acc1);
    send_cmd(32'h200, 8'd1, 2'd1, 3'd2, 4'd9, acc2);
    wait_beats(4);
    vectors++;
    if (acc2 != acc1 + 2) begin
      miscompares++;
      $display("FAIL b2b_accept: second accepted at edge %0d, expected %0d", acc2, acc1 + 2);
    end
    vectors++;
    if (q_data.size() != 4) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d beats, expected 4", q_data.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (q_data[i] !== exp_d[i] || q_id[i] !== exp_id[i] || q_last[i] !== exp_l[i] ||
            q_cyc[i] != q_cyc[0] + i) begin
          miscompares++;
          $display("FAIL b2b_beat%0d: data=%h id=%0d last=%b cyc=%0d, expected data=%h id=%0d last=%b cyc=%0d",
                   i, q_data[i], q_id[i], q_last[i], q_cyc[i], exp_d[i], exp_id[i], exp_l[i], q_cyc[0] + i);
        end
      end
    end
  endtask

  task automatic test_errors();
    int acc;
    clear_q();
    send_cmd(32'h40, 8'd2, 2'd2, 3'd2, 4'd1, acc);
    wait_beats(3);
    vectors++;
    if (q_data.size() != 3) begin
      miscompares++;
      $display("FAIL err_wrap_count: got %0d beats, expected 3", q_data.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (q_data[i] !== 32'h0 || q_resp[i] !== 2'd2 || q_id[i] !== 4'd1 || q_last[i] !== (i == 2)) begin
          miscompares++;
          $display("FAIL err_wrap_beat%0d: data=%h resp=%0d id=%0d last=%b, expected data=0 resp=2 id=1 last=%b",
                   i, q_data[i], q_resp[i], q_id[i], q_last[i], (i == 2));
        end
      end
    end
    clear_q();
    send_cmd(32'h80, 8'd4, 2'd1, 3'd3, 4'd2, acc);
    wait_beats(5);
    vectors++;
    if (q_data.size() != 5) begin
      miscompares++;
      $display("FAIL err_size_count: got %0d beats, expected 5", q_data.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        vectors++;
        if (q_data[i] !== 32'h0 || q_resp[i] !== 2'd2 || q_id[i] !== 4'd2 || q_last[i] !== (i == 4)) begin
          miscompares++;
          $display("FAIL err_size_beat%0d: data=%h resp=%0d id=%0d last=%b, expected data=0 resp=2 id=2 last=%b",
                   i, q_data[i], q_resp[i], q_id[i], q_last[i], (i == 4));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int acc;
    logic [39:0] pat;
    logic        prev_rdy;
    logic        s_valid, s_last;
    logic [31:0] s_data;
    logic [3:0]  s_id;
    pat = 40'hFFFF_FFF6_0B;
    prev_rdy = 1'b1;
    s_valid = 1'b0; s_last = 1'b0; s_data = '0; s_id = '0;
    clear_q();
    send_cmd(32'h1000, 8'd7, 2'd1, 3'd2, 4'd6, acc);
    for (int k = 0; k < 40; k++) begin
      d_ready = pat[k];
      #1;
      if (!prev_rdy) begin
        vectors++;
        if (d_valid !== s_valid || d_data !== s_data || d_last !== s_last || d_id !== s_id) begin
          miscompares++;
          $display("FAIL bp_hold%0d: valid=%b data=%h last=%b id=%0d, expected held valid=%b data=%h last=%b id=%0d",
                   k, d_valid, d_data, d_last, d_id, s_valid, s_data, s_last, s_id);
        end
      end
      if (!d_ready) begin
        vectors++;
        if (u_ready !== 1'b0) begin
          miscompares++;
          $display("FAIL bp_uready%0d: u_ready=%b, expected 0", k, u_ready);
        end
      end
      s_valid = d_valid; s_data = d_data; s_last = d_last; s_id = d_id;
      prev_rdy = d_ready;
      @(negedge clk);
    end
    d_ready = 1'b1;
    wait_beats(8);
    vectors++;
    if (q_data.size() != 8) begin
      miscompares++;
      $display("FAIL bp_count: got %0d beats, expected 8", q_data.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        vectors++;
        if (q_data[i] !== 32'h1000 + 32'(4 * i) || q_id[i] !== 4'd6 || q_last[i] !== (i == 7)) begin
          miscompares++;
          $display("FAIL bp_beat%0d: data=%h id=%0d last=%b, expected data=%h id=6 last=%b",
                   i, q_data[i], q_id[i], q_last[i], 32'h1000 + 32'(4 * i), (i == 7));
        end
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    int acc;
    int guard = 0;
    clear_q();
    send_cmd(32'h300, 8'd7, 2'd1, 3'd2, 4'd4, acc);
    while (q_data.size() < 2 && guard < 50) begin
      @(negedge clk);
      #2;
      guard++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #2;
    vectors++;
    if (d_valid !== 1'b0 || d_last !== 1'b0 || u_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_state: d_valid=%b d_last=%b u_ready=%b, expected 0 0 1", d_valid, d_last, u_ready);
    end
    clear_q();
    repeat (10) @(negedge clk);
    #2;
    vectors++;
    if (q_data.size() != 0) begin
      miscompares++;
      $display("FAIL rstmid_flush: got %0d stray beats, expected 0", q_data.size());
    end
    clear_q();
    send_cmd(32'h400, 8'd1, 2'd1, 3'd2, 4'd7, acc);
    wait_beats(2);
    vectors++;
    if (q_data.size() != 2) begin
      miscompares++;
      $display("FAIL rstmid_next_count: got %0d beats, expected 2", q_data.size());
    end else begin
      vectors++;
      if (q_data[0] !== 32'h400 || q_data[1] !== 32'h404 || q_id[0] !== 4'd7 ||
          q_last[0] !== 1'b0 || q_last[1] !== 1'b1 || q_cyc[0] != acc + 3) begin
        miscompares++;
        $display("FAIL rstmid_next: data=%h,%h id=%0d last=%b,%b cyc=%0d, expected 00000400,00000404 id=7 last=0,1 cyc=%0d",
                 q_data[0], q_data[1], q_id[0], q_last[0], q_last[1], q_cyc[0], acc + 3);
      end
    end
  endtask

  initial begin
    test_reset();
    test_incr();
    test_wrap_fixed();
    test_back_to_back();
    test_errors();
    test_backpressure();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
